id_ex_stage: RTL and testbench

Decode-to-execute pipeline register that sits directly downstream of the register file. It captures the regfile read data (rd1/rd2) together with the decoded instruction fields. It applies a same-cycle writeback bypass, because the regfile write lands on the clock edge and the combinational read would otherwise return stale data. It also detects load-use hazards, inserts bubbles, and presents a valid/ready interface to the execute stage.

---
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It captures the regfile operands and the decoded
// fields, forwards a writeback that lands on the capture edge, refreshes held
// operands, detects load-use hazards and counts the stall cycles they cost.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ADR_WIDTH-1:0]  rs1_adr_i,
    input  logic [ADR_WIDTH-1:0]  rs2_adr_i,
    input  logic                  rs1_used_i,
    input  logic                  rs2_used_i,
    input  logic [ADR_WIDTH-1:0]  rd_adr_i,
    input  logic [DATA_WIDTH-1:0] rd1_i,
    input  logic [DATA_WIDTH-1:0] rd2_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  reg_write_i,
    input  logic                  mem_write_i,
    input  logic                  alu_src_i,
    input  logic [3:0]            alu_ctrl_i,
    input  logic [1:0]            result_src_i,
    input  logic                  wb_we_i,
    input  logic [ADR_WIDTH-1:0]  wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADR_WIDTH-1:0]  ex_rs1_adr_o,
    output logic [ADR_WIDTH-1:0]  ex_rs2_adr_o,
    output logic [ADR_WIDTH-1:0]  ex_rd_adr_o,
    output logic [DATA_WIDTH-1:0] ex_rd1_o,
    output logic [DATA_WIDTH-1:0] ex_rd2_o,
    output logic [DATA_WIDTH-1:0] ex_imm_o,
    output logic [DATA_WIDTH-1:0] ex_pc_o,
    output logic                  ex_reg_write_o,
    output logic                  ex_mem_write_o,
    output logic                  ex_alu_src_o,
    output logic [3:0]            ex_alu_ctrl_o,
    output logic [1:0]            ex_result_src_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    logic                  valid_q,      valid_d;
    logic [ADR_WIDTH-1:0]  rs1_adr_q,    rs1_adr_d;
    logic [ADR_WIDTH-1:0]  rs2_adr_q,    rs2_adr_d;
    logic [ADR_WIDTH-1:0]  rd_adr_q,     rd_adr_d;
    logic [DATA_WIDTH-1:0] rd1_q,        rd1_d;
    logic [DATA_WIDTH-1:0] rd2_q,        rd2_d;
    logic [DATA_WIDTH-1:0] imm_q,        imm_d;
    logic [DATA_WIDTH-1:0] pc_q,         pc_d;
    logic                  reg_write_q,  reg_write_d;
    logic                  mem_write_q,  mem_write_d;
    logic                  alu_src_q,    alu_src_d;
    logic [3:0]            alu_ctrl_q,   alu_ctrl_d;
    logic [1:0]            result_src_q, result_src_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q,  stall_cnt_d;

    logic load_in_stage;
    logic hazard;
    logic capture;
    logic wb_live;
    logic byp1, byp2;
    logic rfr1, rfr2;

    // A load still in execute cannot forward its data in time to a consumer.
    assign load_in_stage = valid_q & reg_write_q & (result_src_q == 2'b01) & (rd_adr_q != '0);
    assign hazard        = load_in_stage &
                           ((rs1_used_i & (rs1_adr_i == rd_adr_q)) |
                            (rs2_used_i & (rs2_adr_i == rd_adr_q)));

    // Flush always accepts so the squashed decode slot is consumed and dropped.
    assign in_ready_o = flush_i | ((~valid_q | out_ready_i) & ~hazard);
    assign capture    = in_valid_i & in_ready_o & ~flush_i;

    // The regfile write lands on the same edge, so forward it; x0 never forwards.
    assign wb_live = wb_we_i & (wb_adr_i != '0);
    assign byp1    = wb_live & (wb_adr_i == rs1_adr_i);
    assign byp2    = wb_live & (wb_adr_i == rs2_adr_i);
    assign rfr1    = wb_live & (wb_adr_i == rs1_adr_q);
    assign rfr2    = wb_live & (wb_adr_i == rs2_adr_q);

    // Next-state selection: flush, then capture, then drain, then hold with refresh.
    always_comb begin
        valid_d      = valid_q;
        rs1_adr_d    = rs1_adr_q;
        rs2_adr_d    = rs2_adr_q;
        rd_adr_d     = rd_adr_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        alu_src_d    = alu_src_q;
        alu_ctrl_d   = alu_ctrl_q;
        result_src_d = result_src_q;
        stall_cnt_d  = stall_cnt_q;

        if (in_valid_i & hazard & ~flush_i & (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end

        if (flush_i) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
        end else if (capture) begin
            valid_d      = 1'b1;
            rs1_adr_d    = rs1_adr_i;
            rs2_adr_d    = rs2_adr_i;
            rd_adr_d     = rd_adr_i;
            rd1_d        = byp1 ? wb_data_i : rd1_i;
            rd2_d        = byp2 ? wb_data_i : rd2_i;
            imm_d        = imm_i;
            pc_d         = pc_i;
            reg_write_d  = reg_write_i;
            mem_write_d  = mem_write_i;
            alu_src_d    = alu_src_i;
            alu_ctrl_d   = alu_ctrl_i;
            result_src_d = result_src_i;
        end else if (valid_q & out_ready_i) begin
            // Drained with nothing behind it: leave a bubble with no side effects.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
        end else if (valid_q) begin
            // Held instruction must not miss writebacks that land while it waits.
            if (rfr1) rd1_d = wb_data_i;
            if (rfr2) rd2_d = wb_data_i;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= 1'b0;
            rs1_adr_q    <= '0;
            rs2_adr_q    <= '0;
            rd_adr_q     <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= '0;
            result_src_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            rs1_adr_q    <= rs1_adr_d;
            rs2_adr_q    <= rs2_adr_d;
            rd_adr_q     <= rd_adr_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            alu_src_q    <= alu_src_d;
            alu_ctrl_q   <= alu_ctrl_d;
            result_src_q <= result_src_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid_o     = valid_q;
    assign ex_rs1_adr_o    = rs1_adr_q;
    assign ex_rs2_adr_o    = rs2_adr_q;
    assign ex_rd_adr_o     = rd_adr_q;
    assign ex_rd1_o        = rd1_q;
    assign ex_rd2_o        = rd2_q;
    assign ex_imm_o        = imm_q;
    assign ex_pc_o         = pc_q;
    assign ex_reg_write_o  = reg_write_q;
    assign ex_mem_write_o  = mem_write_q;
    assign ex_alu_src_o    = alu_src_q;
    assign ex_alu_ctrl_o   = alu_ctrl_q;
    assign ex_result_src_o = result_src_q;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: bypass vector table, hand-written multi-cycle
// sequences, and random traffic against a regfile + one-slot transaction model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_used, rs2_used;
    logic [31:0] rd1, rd2, imm, pc;
    logic        rw, mw, asrc;
    logic [3:0]  actl;
    logic [1:0]  rsrc;
    logic        wb_we;
    logic [4:0]  wb_adr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
    logic        ex_rw, ex_mw, ex_asrc;
    logic [3:0]  ex_actl;
    logic [1:0]  ex_rsrc;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DATA_WIDTH(32), .ADR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rs1_adr_i(rs1), .rs2_adr_i(rs2), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
        .rd_adr_i(rd), .rd1_i(rd1), .rd2_i(rd2), .imm_i(imm), .pc_i(pc),
        .reg_write_i(rw), .mem_write_i(mw), .alu_src_i(asrc),
        .alu_ctrl_i(actl), .result_src_i(rsrc),
        .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_data_i(wb_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .ex_rs1_adr_o(ex_rs1), .ex_rs2_adr_o(ex_rs2), .ex_rd_adr_o(ex_rd),
        .ex_rd1_o(ex_rd1), .ex_rd2_o(ex_rd2), .ex_imm_o(ex_imm), .ex_pc_o(ex_pc),
        .ex_reg_write_o(ex_rw), .ex_mem_write_o(ex_mw), .ex_alu_src_o(ex_asrc),
        .ex_alu_ctrl_o(ex_actl), .ex_result_src_o(ex_rsrc),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        in_valid = 0; flush = 0; out_ready = 1;
        rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0;
        rd1 = 0; rd2 = 0; imm = 0; pc = 0;
        rw = 0; mw = 0; asrc = 0; actl = 0; rsrc = 0;
        wb_we = 0; wb_adr = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        set_idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] rd1, rd2;
        logic        wb_we;
        logic [4:0]  wb_adr;
        logic [31:0] wb_data, exp1, exp2;
    } vec_t;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm, pc;
        logic        rw, mw, asrc;
        logic [3:0]  actl;
        logic [1:0]  rsrc;
    } ins_t;

    vec_t        vecs [8];
    logic [31:0] rf [32];
    ins_t        m_ins;
    logic        m_valid;
    int          m_cnt;
    logic        m_haz, m_ready;

    initial begin
        vecs[0] = '{5'd1,  5'd2,  32'h1111, 32'h2222, 1'b1, 5'd1,  32'hDEAD, 32'hDEAD, 32'h2222};
        vecs[1] = '{5'd1,  5'd2,  32'h1111, 32'h2222, 1'b1, 5'd0,  32'hDEAD, 32'h1111, 32'h2222};
        vecs[2] = '{5'd0,  5'd0,  32'h0,    32'h0,    1'b1, 5'd0,  32'hBEEF, 32'h0,    32'h0};
        vecs[3] = '{5'd3,  5'd4,  32'h3333, 32'h4444, 1'b1, 5'd4,  32'hCAFE, 32'h3333, 32'hCAFE};
        vecs[4] = '{5'd7,  5'd7,  32'h7777, 32'h7777, 1'b1, 5'd7,  32'h1234, 32'h1234, 32'h1234};
        vecs[5] = '{5'd3,  5'd4,  32'h3333, 32'h4444, 1'b0, 5'd3,  32'h5555, 32'h3333, 32'h4444};
        vecs[6] = '{5'd8,  5'd9,  32'h8888, 32'h9999, 1'b1, 5'd10, 32'hAAAA, 32'h8888, 32'h9999};
        vecs[7] = '{5'd31, 5'd30, 32'h1F1F, 32'h1E1E, 1'b1, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1E1E};

        // Reset state
        set_idle();
        rst_n = 0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_ex_rd1", 64'(ex_rd1), 64'(0));
        chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        tick();
        rst_n = 1;
        #1;

        // ADD capture then drain
        in_valid = 1; rs1 = 1; rd1 = 5; rs2 = 2; rd2 = 7; rd = 3;
        rs1_used = 1; rs2_used = 1; rw = 1;
        tick();
        chk("add_valid", 64'(out_valid), 64'(1));
        chk("add_rd1", 64'(ex_rd1), 64'(5));
        chk("add_rd2", 64'(ex_rd2), 64'(7));
        chk("add_rd_adr", 64'(ex_rd), 64'(3));
        in_valid = 0;
        tick();
        chk("drain_valid", 64'(out_valid), 64'(0));
        chk("drain_reg_write", 64'(ex_rw), 64'(0));
        chk("drain_hold_rd1", 64'(ex_rd1), 64'(5));

        // Capture-bypass vector table
        set_idle();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; rs1_used = 1; rs2_used = 1;
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            rd1 = vecs[i].rd1; rd2 = vecs[i].rd2;
            wb_we = vecs[i].wb_we; wb_adr = vecs[i].wb_adr; wb_data = vecs[i].wb_data;
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
            chk($sformatf("vec%0d_rd1", i), 64'(ex_rd1), 64'(vecs[i].exp1));
            chk($sformatf("vec%0d_rd2", i), 64'(ex_rd2), 64'(vecs[i].exp2));
        end
        set_idle();
        tick();

        // Load-use: one bubble, one stall cycle
        in_valid = 1; rd = 5; rw = 1; rsrc = 2'b01; rs1 = 1; rs1_used = 1;
        tick();
        rs1 = 2; rs2 = 5; rs2_used = 1; rd = 6; rsrc = 2'b00;
        #1;
        chk("lu_in_ready_low", 64'(in_ready), 64'(0));
        tick();
        chk("lu_bubble", 64'(out_valid), 64'(0));
        chk("lu_stall_cnt", 64'(stall_cnt), 64'(1));
        chk("lu_in_ready_high", 64'(in_ready), 64'(1));
        tick();
        chk("lu_dep_valid", 64'(out_valid), 64'(1));
        chk("lu_dep_rd", 64'(ex_rd), 64'(6));
        chk("lu_dep_rs2", 64'(ex_rs2), 64'(5));
        set_idle();
        tick();

        // Hold with stale-operand refresh
        in_valid = 1; rs1 = 6; rs1_used = 1; rd = 7; rd1 = 32'h10; rw = 1; out_ready = 0;
        tick();
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_rd1_init", 64'(ex_rd1), 64'(32'h10));
        in_valid = 0; wb_we = 1; wb_adr = 6; wb_data = 32'h42;
        tick();
        chk("hold_rd1_refresh", 64'(ex_rd1), 64'(32'h42));
        chk("hold_still_valid", 64'(out_valid), 64'(1));
        wb_we = 0; out_ready = 1;
        tick();
        chk("hold_consumed", 64'(out_valid), 64'(0));
        tick();
        chk("hold_consumed_once", 64'(out_valid), 64'(0));

        // Flush over a held load with a dependent offer
        set_idle();
        in_valid = 1; rd = 9; rw = 1; mw = 1; rsrc = 2'b01; out_ready = 0;
        tick();
        chk("fl_pre_mw", 64'(ex_mw), 64'(1));
        flush = 1; rs1 = 9; rs1_used = 1; rd = 10; rsrc = 2'b00;
        #1;
        chk("fl_in_ready", 64'(in_ready), 64'(1));
        tick();
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_reg_write", 64'(ex_rw), 64'(0));
        chk("fl_mem_write", 64'(ex_mw), 64'(0));
        chk("fl_stall_cnt", 64'(stall_cnt), 64'(1));

        // Random traffic vs regfile + one-slot model
        reset_dut();
        for (int r = 0; r < 32; r++) rf[r] = 32'h0;
        m_valid = 0;
        m_cnt = 0;
        m_ins = '{default: '0};
        @(posedge clk);
        #1;
        for (int it = 0; it < 3000; it++) begin
            flush    = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
            rd       = 5'($urandom_range(0, 7));
            rs1_used = 1'($urandom_range(0, 1));
            rs2_used = 1'($urandom_range(0, 1));
            rw       = 1'($urandom_range(0, 1));
            mw       = 1'($urandom_range(0, 1));
            asrc     = 1'($urandom_range(0, 1));
            actl     = 4'($urandom_range(0, 15));
            rsrc     = 2'($urandom_range(0, 2));
            imm      = $urandom;
            pc       = $urandom;
            rd1      = rf[rs1];
            rd2      = rf[rs2];
            wb_we    = 1'($urandom_range(0, 1));
            wb_adr   = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            m_haz = m_valid && m_ins.rw && (m_ins.rsrc == 2'b01) && (m_ins.rd != 0) &&
                    ((rs1_used && rs1 == m_ins.rd) || (rs2_used && rs2 == m_ins.rd));
            m_ready = flush || ((!m_valid || out_ready) && !m_haz);
            chk("rnd_in_ready", 64'(in_ready), 64'(m_ready));
            chk("rnd_valid", 64'(out_valid), 64'(m_valid));
            chk("rnd_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
            if (m_valid) begin
                chk("rnd_rd_adr", 64'(ex_rd), 64'(m_ins.rd));
                chk("rnd_rs1_adr", 64'(ex_rs1), 64'(m_ins.rs1));
                chk("rnd_rs2_adr", 64'(ex_rs2), 64'(m_ins.rs2));
                chk("rnd_imm", 64'(ex_imm), 64'(m_ins.imm));
                chk("rnd_pc", 64'(ex_pc), 64'(m_ins.pc));
                chk("rnd_ctrl", 64'({ex_rw, ex_mw, ex_asrc, ex_actl, ex_rsrc}),
                    64'({m_ins.rw, m_ins.mw, m_ins.asrc, m_ins.actl, m_ins.rsrc}));
                chk("rnd_rd1", 64'(ex_rd1), 64'(rf[m_ins.rs1]));
                chk("rnd_rd2", 64'(ex_rd2), 64'(rf[m_ins.rs2]));
            end else begin
                chk("rnd_bubble_ctrl", 64'({ex_rw, ex_mw}), 64'(0));
            end
            @(posedge clk);
            if (in_valid && m_haz && !flush && m_cnt < 65535) m_cnt++;
            if (flush) m_valid = 0;
            else if (in_valid && m_ready) begin
                m_valid = 1;
                m_ins = '{rs1, rs2, rd, imm, pc, rw, mw, asrc, actl, rsrc};
            end else if (m_valid && out_ready) m_valid = 0;
            if (wb_we && wb_adr != 0) rf[wb_adr] = wb_data;
            #1;
        end

        // Sustained hazard: counter saturation, then asynchronous reset
        reset_dut();
        tick();
        in_valid = 1; rd = 5; rw = 1; rsrc = 2'b01; out_ready = 0;
        tick();
        rs1 = 5; rs1_used = 1; rd = 6; rsrc = 2'b00;
        #1;
        chk("sat_in_ready", 64'(in_ready), 64'(0));
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_near_top", 64'(stall_cnt), 64'(16'hFFFE));
        repeat (8) @(posedge clk);
        #1;
        chk("sat_top", 64'(stall_cnt), 64'(16'hFFFF));
        chk("sat_load_held", 64'(out_valid), 64'(1));
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_stall_cnt", 64'(stall_cnt), 64'(0));
        chk("arst_rd_adr", 64'(ex_rd), 64'(0));
        chk("arst_ctrl", 64'({ex_rw, ex_mw, ex_rsrc}), 64'(0));
        #3;
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
